// File: rtl/vect_pkg.sv
// rtl/vect_pkg.sv - shared AHB-Lite encodings for the vector-core bus
package vect_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } ahb_htrans_e;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Byte-lane enables for a legal (aligned, size<=word) transfer.
  function automatic logic [3:0] ahb_byte_en(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: return 4'b0001 << addr_lo;
      HSIZE_HALF: return 4'b0011 << addr_lo;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// rtl/ahb_sram_slave_if.sv - AHB-Lite slave-side signal bundle
interface ahb_sram_slave_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  hsel_i;
  logic [DATA_WIDTH-1:0] haddr_i;
  logic [1:0]            htrans_i;
  logic                  hwrite_i;
  logic [2:0]            hsize_i;
  logic [DATA_WIDTH-1:0] hwdata_i;
  logic                  hready_i;
  logic [DATA_WIDTH-1:0] hrdata_o;
  logic                  hreadyout_o;
  logic [1:0]            hresp_o;

  modport slave (
    input  hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
    output hrdata_o, hreadyout_o, hresp_o
  );

  modport master (
    output hsel_i, haddr_i, htrans_i, hwrite_i, hsize_i, hwdata_i, hready_i,
    input  hrdata_o, hreadyout_o, hresp_o
  );
endinterface

// File: rtl/ahb_sram_array.sv
// rtl/ahb_sram_array.sv - single-port SRAM, byte-enabled sync write, async read
module ahb_sram_array #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite responder in front of a word-organised SRAM
module ahb_sram_slave
  import vect_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input logic             clk_i,
  input logic             resetn_i,
  ahb_sram_slave_if.slave bus
);

  localparam int         AW      = $clog2(MEM_WORDS);
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } ahb_slv_fsm_t;

  ahb_slv_fsm_t          state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [AW+1:0]         addr_q, addr_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [DATA_WIDTH-1:0] hold_q;

  logic        accept, illegal, misaligned, out_of_range;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic        ready_d;
  logic [1:0]  resp_d;

  assign accept = bus.hsel_i && bus.hready_i &&
                  (bus.htrans_i == HTRANS_NONSEQ || bus.htrans_i == HTRANS_SEQ);

  assign misaligned   = (bus.hsize_i == HSIZE_HALF && bus.haddr_i[0]) ||
                        (bus.hsize_i == HSIZE_WORD && bus.haddr_i[1:0] != 2'b00);
  assign out_of_range = bus.haddr_i[31:AW+2] != BASE_ADDR[31:AW+2];
  assign illegal      = (bus.hsize_i > HSIZE_WORD) || misaligned || out_of_range;

  // pend_q marks the final OKAY data-phase cycle; writes commit at its closing edge.
  assign mem_we = pend_q && write_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    ready_d = 1'b1;
    resp_d  = HRESP_OKAY;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        if (state_q == ST_ERR2) resp_d = HRESP_ERROR;
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = bus.haddr_i[AW+1:0];
          write_d = bus.hwrite_i;
          size_d  = bus.hsize_i;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_INIT;
          end else begin
            pend_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        ready_d = 1'b0;
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          pend_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        ready_d = 1'b0;
        resp_d  = HRESP_ERROR;
        state_d = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= HSIZE_BYTE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      hold_q  <= bus.hrdata_o;
    end
  end

  ahb_sram_array #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .be_i    (ahb_byte_en(size_q, addr_q[1:0])),
    .addr_i  (addr_q[AW+1:2]),
    .wdata_i (bus.hwdata_i),
    .rdata_o (mem_rdata)
  );

  // Read data is live only on a read completion, otherwise the last value is held.
  assign bus.hrdata_o    = (pend_q && !write_q) ? mem_rdata : hold_q;
  assign bus.hreadyout_o = ready_d;
  assign bus.hresp_o     = resp_d;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - directed self-checking bench for ahb_sram_slave
module tb_ahb_sram_slave;
  import vect_pkg::*;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = '0;
  int          sel = 0;
  int          nchk = 0;
  int          nfail = 0;

  logic [31:0] rd;
  logic        rdy;
  logic [1:0]  rsp;

  always #5 clk = ~clk;

  ahb_sram_slave_if #(.DATA_WIDTH(32)) if0 ();
  ahb_sram_slave_if #(.DATA_WIDTH(32)) if3 ();
  ahb_sram_slave_if #(.DATA_WIDTH(32)) if4 ();

  assign if0.hsel_i = hsel && (sel == 0);
  assign if3.hsel_i = hsel && (sel == 1);
  assign if4.hsel_i = hsel && (sel == 2);
  assign if0.haddr_i = haddr;   assign if3.haddr_i = haddr;   assign if4.haddr_i = haddr;
  assign if0.htrans_i = htrans; assign if3.htrans_i = htrans; assign if4.htrans_i = htrans;
  assign if0.hwrite_i = hwrite; assign if3.hwrite_i = hwrite; assign if4.hwrite_i = hwrite;
  assign if0.hsize_i = hsize;   assign if3.hsize_i = hsize;   assign if4.hsize_i = hsize;
  assign if0.hwdata_i = hwdata; assign if3.hwdata_i = hwdata; assign if4.hwdata_i = hwdata;
  assign if0.hready_i = if0.hreadyout_o;
  assign if3.hready_i = if3.hreadyout_o;
  assign if4.hready_i = if4.hreadyout_o;

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (.clk_i(clk), .resetn_i(resetn), .bus(if0));
  ahb_sram_slave #(.WAIT_STATES(3)) dut3 (.clk_i(clk), .resetn_i(resetn), .bus(if3));
  ahb_sram_slave #(.WAIT_STATES(4)) dut4 (.clk_i(clk), .resetn_i(resetn), .bus(if4));

  always_comb begin
    case (sel)
      1:       begin rd = if3.hrdata_o; rdy = if3.hreadyout_o; rsp = if3.hresp_o; end
      2:       begin rd = if4.hrdata_o; rdy = if4.hreadyout_o; rsp = if4.hresp_o; end
      default: begin rd = if0.hrdata_o; rdy = if0.hreadyout_o; rsp = if0.hresp_o; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic addr_phase(input logic w, input logic [2:0] sz, input logic [31:0] a);
    hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = w; hsize = sz; haddr = a;
  endtask

  task automatic go_idle();
    htrans = HTRANS_IDLE; hwrite = 1'b0;
  endtask

  // One non-pipelined transfer; counts wait cycles with a bounded loop.
  task automatic single(input string tag, input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input int exp_wait, input logic [31:0] exp_rd);
    int waits;
    addr_phase(w, sz, a);
    @(posedge clk); #1;
    go_idle(); hwdata = wd;
    waits = 0;
    @(negedge clk);
    while (!rdy && waits < 40) begin
      waits++;
      @(negedge clk);
    end
    check({tag, "_waits"}, 32'(waits), 32'(exp_wait));
    check({tag, "_resp"}, {30'd0, rsp}, {30'd0, HRESP_OKAY});
    if (!w) check({tag, "_rdata"}, rd, exp_rd);
    @(posedge clk); #1;
  endtask

  task automatic err_xfer(input string tag, input logic w, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd);
    addr_phase(w, sz, a);
    @(posedge clk); #1;
    go_idle(); hwdata = wd;
    @(negedge clk);
    check({tag, "_e1"}, {29'd0, rdy, rsp}, {29'd0, 1'b0, HRESP_ERROR});
    @(negedge clk);
    check({tag, "_e2"}, {29'd0, rdy, rsp}, {29'd0, 1'b1, HRESP_ERROR});
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ws0", {if0.hrdata_o[31:0], 1'b0, if0.hreadyout_o, if0.hresp_o}, {32'd0, 1'b0, 1'b1, HRESP_OKAY});
    check("rst_ws3", {if3.hrdata_o[31:0], 1'b0, if3.hreadyout_o, if3.hresp_o}, {32'd0, 1'b0, 1'b1, HRESP_OKAY});
    check("rst_ws4", {if4.hrdata_o[31:0], 1'b0, if4.hreadyout_o, if4.hresp_o}, {32'd0, 1'b0, 1'b1, HRESP_OKAY});
    resetn = 1'b1;
    @(posedge clk); #1;

    // zero-wait: write then back-to-back read of the same word
    sel = 0;
    addr_phase(1'b1, HSIZE_WORD, 32'h10);
    @(negedge clk); check("zw_a_rdy", {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    hwdata = 32'hDEADBEEF; addr_phase(1'b0, HSIZE_WORD, 32'h10);
    @(negedge clk); check("zw_w_rdy", {31'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk);
    check("zw_r_rdy", {31'd0, rdy}, 32'd1);
    check("zw_r_data", rd, 32'hDEADBEEF);
    @(posedge clk); #1;

    // sub-word writes, pipelined
    addr_phase(1'b1, HSIZE_WORD, 32'h40);
    @(posedge clk); #1;
    hwdata = 32'h0; addr_phase(1'b1, HSIZE_BYTE, 32'h41);
    @(posedge clk); #1;
    hwdata = 32'h0000_AA00; addr_phase(1'b1, HSIZE_HALF, 32'h42);
    @(posedge clk); #1;
    hwdata = 32'h1234_0000; addr_phase(1'b0, HSIZE_WORD, 32'h40);
    @(posedge clk); #1;
    go_idle();
    @(negedge clk); check("sub_rdata", rd, 32'h1234AA00);
    @(posedge clk); #1;

    // IDLE, BUSY and deselected write must not touch the SRAM
    hsel = 1'b1; htrans = HTRANS_IDLE; hwrite = 1'b1; haddr = 32'h40;
    @(negedge clk); check("idle_ok", {29'd0, rdy, rsp}, {29'd0, 1'b1, HRESP_OKAY});
    @(posedge clk); #1;
    hwdata = 32'hFFFF_FFFF; htrans = HTRANS_BUSY;
    @(negedge clk); check("busy_ok", {29'd0, rdy, rsp}, {29'd0, 1'b1, HRESP_OKAY});
    @(posedge clk); #1;
    hsel = 1'b0; htrans = HTRANS_NONSEQ; hsize = HSIZE_WORD;
    @(posedge clk); #1;
    go_idle();
    @(negedge clk); check("desel_ok", {29'd0, rdy, rsp}, {29'd0, 1'b1, HRESP_OKAY});
    @(posedge clk); #1;
    single("desel_rd", 1'b0, HSIZE_WORD, 32'h40, 32'h0, 0, 32'h1234AA00);

    // error responses leave the SRAM unchanged
    single("w0", 1'b1, HSIZE_WORD, 32'h0, 32'hCAFEF00D, 0, 32'h0);
    err_xfer("mis_rd", 1'b0, HSIZE_WORD, 32'h3, 32'h0);
    err_xfer("oor_wr", 1'b1, HSIZE_WORD, 32'h1000, 32'h5555_5555);
    err_xfer("mis_half", 1'b1, HSIZE_HALF, 32'h11, 32'h5555_5555);
    single("post_err0", 1'b0, HSIZE_WORD, 32'h0, 32'h0, 0, 32'hCAFEF00D);
    single("post_err10", 1'b0, HSIZE_WORD, 32'h10, 32'h0, 0, 32'hDEADBEEF);

    // three wait states
    sel = 1;
    single("ws3_wr", 1'b1, HSIZE_WORD, 32'h20, 32'hA5A5_0F0F, 3, 32'h0);
    single("ws3_rd", 1'b0, HSIZE_WORD, 32'h20, 32'h0, 3, 32'hA5A5_0F0F);
    err_xfer("ws3_size", 1'b0, 3'd3, 32'h20, 32'h0);

    // reset in the middle of a waited write drops it
    sel = 2;
    single("ws4_wr", 1'b1, HSIZE_WORD, 32'h50, 32'h1357_2468, 4, 32'h0);
    single("ws4_rd", 1'b0, HSIZE_WORD, 32'h50, 32'h0, 4, 32'h1357_2468);
    addr_phase(1'b1, HSIZE_WORD, 32'h50);
    @(posedge clk); #1;
    go_idle(); hwdata = 32'hFFFF_0000;
    @(negedge clk); check("mid_w1", {31'd0, rdy}, 32'd0);
    @(negedge clk); check("mid_w2", {31'd0, rdy}, 32'd0);
    #1 resetn = 1'b0;
    #1;
    check("mid_rst", {rd, 1'b0, rdy, rsp}, {32'd0, 1'b0, 1'b1, HRESP_OKAY});
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    single("ws4_after", 1'b0, HSIZE_WORD, 32'h50, 32'h0, 4, 32'h1357_2468);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite responder that fronts a word-organised on-chip SRAM.
- Serves as the memory target for the vector load/store unit's AHB master port, and for any other AHB master on the vector-core bus.
- Supports byte, halfword and word transfers, a configurable number of wait states, and the standard two-cycle ERROR response for illegal accesses.

Parameters:
- DATA_WIDTH, 32, bus data/address width; only 32 is supported.
- MEM_WORDS, 1024, SRAM depth in 32-bit words; must be a power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to MEM_WORDS*4.
- WAIT_STATES, 1, number of hreadyout_o=0 cycles inserted per OKAY data phase (0..15).

Ports:
- clk_i  in  1  clock.
- resetn_i  in  1  asynchronous, active-low reset.
- hsel_i  in  1  slave select from the address decoder.
- haddr_i  in  DATA_WIDTH  byte address (address phase).
- htrans_i  in  2  IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- hwrite_i  in  1  1=write, 0=read.
- hsize_i  in  3  0=byte, 1=half, 2=word.
- hwdata_i  in  DATA_WIDTH  write data (data phase).
- hready_i  in  1  bus-level HREADY; qualifies the address phase.
- hrdata_o  out  DATA_WIDTH  read data.
- hreadyout_o  out  1  slave ready.
- hresp_o  out  2  OKAY=0, ERROR=1.

Behaviour:
- Reset values: hreadyout_o=1, hresp_o=OKAY, hrdata_o=0, state=ST_IDLE, wait counter=0. SRAM contents are not reset.
- Reset asserted mid-transfer aborts it; any pending write is dropped.
- Address phase is accepted when hsel_i && htrans_i[1] && hready_i. On acceptance, haddr, hwrite and hsize are registered.
- IDLE or BUSY transfers, or hsel_i=0, get a zero-wait OKAY and cause no access.
- A transfer is illegal if any of these holds:
  - hsize_i>2;
  - the address is misaligned for its size (half: haddr[0]!=0; word: haddr[1:0]!=0);
  - haddr_i is outside BASE_ADDR .. BASE_ADDR+MEM_WORDS*4-1.
- State machine: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2.
  - ST_IDLE: accepted legal transfer with WAIT_STATES>0 -> ST_WAIT, counter loaded with WAIT_STATES-1. Accepted legal transfer with WAIT_STATES=0 -> stays in the data phase with hreadyout_o=1. Accepted illegal transfer -> ST_ERR1.
  - ST_WAIT: hreadyout_o=0, hresp_o=OKAY. Counter decrements each cycle. When the counter is 0, the next cycle is the final data-phase cycle (hreadyout_o=1).
  - ST_ERR1: hreadyout_o=0, hresp_o=ERROR -> ST_ERR2.
  - ST_ERR2: hreadyout_o=1, hresp_o=ERROR. No SRAM access. Returns to the address-phase logic.
- Final data-phase cycle (hreadyout_o=1, OKAY):
  - Read: hrdata_o = SRAM word at the registered address, full 32 bits, unshifted (the master selects byte lanes).
  - Write: hwdata_i is sampled on this clock edge and committed with byte enables: byte -> 1 << addr[1:0]; half -> 4'b0011 << addr[1:0]; word -> 4'b1111.
- Pipelining: a new address phase may be accepted in the same cycle as the final data-phase cycle (hreadyout_o=1). Back-to-back zero-wait transfers therefore sustain one transfer per cycle.
- During ST_WAIT and ST_ERR1, hready_i=0, so no address phase is accepted.
- Read-after-write to the same word, back-to-back: the read returns the newly written data. The write commits on the edge that starts the read's data phase, and the array read uses the registered address.
- hrdata_o holds its last value outside read completions. It is 0 after reset and must not be X.
- Latency: a read completes WAIT_STATES+1 cycles after the address phase. An error completes 2 cycles after the address phase.

Decomposition:
- Shared package (vect_pkg):
  - htrans enum ahb_htrans_e {HTRANS_IDLE, HTRANS_BUSY, HTRANS_NONSEQ, HTRANS_SEQ};
  - hresp constants HRESP_OKAY and HRESP_ERROR;
  - existing HSIZE_BYTE, HSIZE_HALF, HSIZE_WORD.
- State enum ahb_slv_fsm_t stays local to the module.
- One sub-module: ahb_sram_array. It is a single-port, synchronous-write, asynchronous-read, 4-byte-enable memory with MEM_WORDS entries, and can be swapped for a foundry macro.

Test Plan:
- Zero-wait word write then read (WAIT_STATES=0):
  - Stimulus: write 32'hDEADBEEF to 0x10, then NONSEQ read of 0x10 in the next cycle.
  - Required: hreadyout_o stays 1 throughout; the read returns 32'hDEADBEEF one cycle after its address phase.
- Wait states (WAIT_STATES=3):
  - Stimulus: read of 0x20.
  - Required: hreadyout_o=0 for exactly 3 cycles, then 1 with valid data and hresp_o=OKAY.
- Sub-word writes:
  - Stimulus: word write 0x0 to 0x40; byte write 0xAA to 0x41; half write 0x1234 to 0x42; word read of 0x40.
  - Required: read returns 32'h1234AA00.
- Error response:
  - Stimulus: word read of 0x3 (misaligned), then word write to BASE_ADDR+MEM_WORDS*4.
  - Required: each gives hreadyout_o=0/hresp_o=ERROR, then hreadyout_o=1/hresp_o=ERROR. The SRAM is unchanged afterwards.
- IDLE, BUSY and deselect:
  - Stimulus: htrans=IDLE with hsel=1; htrans=NONSEQ with hsel=0 and hwrite=1 to 0x40.
  - Required: zero-wait OKAY, and the word at 0x40 is unmodified.
- Reset mid-transfer (WAIT_STATES=4):
  - Stimulus: assert resetn_i low during ST_WAIT of a write to 0x50.
  - Required: outputs return immediately to reset values; the word at 0x50 is not written; the next read succeeds.
